token_sequencer: RTL and testbench
==================================

TOKEN_SEQUENCER -- requirements
Module: token_sequencer

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent token channels, legal range 1..16.
REQ-002 Parameter TOKEN_W, default 8: token and max-value width in bits, legal range 2..16.
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 cfg_valid  in  1  configuration write strobe; accepted on every cycle it is high (no backpressure).
REQ-006 cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel of the configuration write.
REQ-007 cfg_max  in  TOKEN_W  terminal token value for the target channel.
REQ-008 cfg_mode  in  2  channel mode: 0 = WRAP, 1 = ONESHOT, 2 = PINGPONG, 3 = reserved.
REQ-009 ch_en  in  NUM_CH  per-channel advance enable.
REQ-010 ch_clear  in  NUM_CH  per-channel restart to token 0.
REQ-011 token  out  NUM_CH*TOKEN_W  registered current tokens, channel i at bits [i*TOKEN_W +: TOKEN_W].
REQ-012 wrap_pulse  out  NUM_CH  registered one-cycle pulse per channel on return to 0.
REQ-013 done  out  NUM_CH  registered level, high while the channel is in DONE.
REQ-014 all_done  out  1  registered AND of done across all channels.
REQ-015 cfg_err  out  1  registered one-cycle pulse on a rejected configuration write.

Function
REQ-016 Each channel SHALL hold the state IDLE, RUN or DONE, plus max, mode, direction and token registers.
REQ-017 Per-channel priority SHALL be: reset, then configuration, then ch_clear, then ch_en.
REQ-018 An accepted write SHALL load max and mode, set token = 0, set direction = up, clear done, and enter RUN, regardless of the channel's prior state or its ch_en/ch_clear in that cycle.
REQ-019 cfg_ch >= NUM_CH or cfg_mode = 3 SHALL reject the write, leave all channels unchanged, and pulse cfg_err on the next cycle.
REQ-020 ch_clear in RUN or DONE SHALL set token = 0 and direction = up, and put the channel in RUN; in IDLE it SHALL have no effect.
REQ-021 The token SHALL change only in RUN with ch_en high; IDLE and DONE SHALL hold the token.
REQ-022 WRAP: token < max SHALL increment; token == max SHALL load 0 and assert wrap_pulse in the same cycle that token shows 0.
REQ-023 ONESHOT: token < max SHALL increment; token == max SHALL enter DONE with token held at max, done = 1 from the next cycle, and no wrap_pulse.
REQ-024 PINGPONG (up): token < max SHALL increment; token == max SHALL reverse to down and decrement, so max is shown for one enabled cycle.
REQ-025 PINGPONG (down): decrement while token > 0; token 1 -> 0 SHALL assert wrap_pulse and reverse to up.
REQ-026 max = 0: the token SHALL stay 0. WRAP and PINGPONG SHALL pulse wrap_pulse on every enabled cycle; ONESHOT SHALL enter DONE on the first enabled cycle.
REQ-027 Arithmetic SHALL be TOKEN_W-bit unsigned and never overflow; the token SHALL never exceed max, including max = 2^TOKEN_W-1.
REQ-028 wrap_pulse SHALL be low on every cycle not named in REQ-022, REQ-025 and REQ-026.
REQ-029 Latency from an input edge to the corresponding output change SHALL be exactly one clock; all outputs SHALL be driven from registers, with no combinational input-to-output path.
REQ-030 Channels SHALL be fully independent; one write per cycle SHALL touch only the addressed channel.

Reset
REQ-031 Asserting reset SHALL immediately force: all tokens 0, max 0, mode WRAP, direction up, state IDLE.
REQ-032 Asserting reset SHALL immediately drive wrap_pulse, done, all_done and cfg_err to 0.
REQ-033 Reset asserted mid-operation SHALL abort all counting; after release every channel SHALL stay IDLE until configured.

Verification
REQ-034 WRAP: ch0 WRAP max=3, ch_en[0]=1 -> token0 0,1,2,3,0,1; wrap_pulse[0] high only on the cycles token0 returns to 0.
REQ-035 ONESHOT: ch1 ONESHOT max=2 -> token1 0,1,2,2...; done[1] rises on the cycle after token1 first shows 2; ch_clear[1] -> token1=0, done[1]=0.
REQ-036 PINGPONG: ch2 PINGPONG max=2 -> token2 0,1,2,1,0,1,2; wrap_pulse[2] high when token2 shows 0 on the down-count.
REQ-037 Simultaneous events: ch_en=1, ch_clear=1 and a write max=5 to ch3 in one cycle -> token3=0, mode/max from the write; cfg_ch=NUM_CH -> cfg_err pulses once and no state changes.
REQ-038 Boundaries: max=0 in WRAP -> token 0 with wrap_pulse every enabled cycle; max=255 with TOKEN_W=8 -> 254,255,0 and no overflow.
REQ-039 Mid-count reset: reset asserted with the token at 2 -> outputs 0 within the same cycle; ch_en=1 after release -> token stays 0 (IDLE).
REQ-040 all_done: all channels ONESHOT -> all_done rises one cycle after the last done rises.

Source files
------------

// File: rtl/token_sequencer.sv
// token_sequencer: NUM_CH independent token counters, each running in WRAP,
// ONESHOT or PINGPONG mode against a per-channel terminal value. Each channel
// is configured through a shared write port. All outputs come from registers.
module token_sequencer #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned TOKEN_W = 8
) (
  input  logic                                           clk_i,
  input  logic                                           rst_i,
  input  logic                                           cfg_valid_i,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch_i,
  input  logic [TOKEN_W-1:0]                             cfg_max_i,
  input  logic [1:0]                                     cfg_mode_i,
  input  logic [NUM_CH-1:0]                              ch_en_i,
  input  logic [NUM_CH-1:0]                              ch_clear_i,
  output logic [NUM_CH*TOKEN_W-1:0]                      token_o,
  output logic [NUM_CH-1:0]                              wrap_pulse_o,
  output logic [NUM_CH-1:0]                              done_o,
  output logic                                           all_done_o,
  output logic                                           cfg_err_o
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'd0,
    MODE_ONESHOT  = 2'd1,
    MODE_PINGPONG = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_e;

  // Per-channel registered state
  state_e               state_q [NUM_CH];
  state_e               state_d [NUM_CH];
  mode_e                mode_q  [NUM_CH];
  mode_e                mode_d  [NUM_CH];
  logic [TOKEN_W-1:0]   max_q   [NUM_CH];
  logic [TOKEN_W-1:0]   max_d   [NUM_CH];
  logic [TOKEN_W-1:0]   tok_q   [NUM_CH];
  logic [TOKEN_W-1:0]   tok_d   [NUM_CH];
  logic [NUM_CH-1:0]    down_q;
  logic [NUM_CH-1:0]    down_d;
  logic [NUM_CH-1:0]    wrap_q;
  logic [NUM_CH-1:0]    wrap_d;
  logic [NUM_CH-1:0]    done_q;
  logic [NUM_CH-1:0]    done_d;
  logic                 all_done_q;
  logic                 all_done_d;
  logic                 cfg_err_q;
  logic                 cfg_err_d;

  logic                 cfg_ok;

  // Write is legal only for an existing channel and a defined mode
  assign cfg_ok = (32'(cfg_ch_i) < NUM_CH) && (cfg_mode_i != 2'd3);

  // Next-state logic for every channel: config > clear > enable
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      mode_d[i]  = mode_q[i];
      max_d[i]   = max_q[i];
      tok_d[i]   = tok_q[i];
      down_d[i]  = down_q[i];
      wrap_d[i]  = 1'b0;

      if (cfg_valid_i && cfg_ok && (cfg_ch_i == CH_W'(i))) begin
        max_d[i]   = cfg_max_i;
        mode_d[i]  = mode_e'(cfg_mode_i);
        tok_d[i]   = '0;
        down_d[i]  = 1'b0;
        state_d[i] = ST_RUN;
      end else if (ch_clear_i[i] && (state_q[i] != ST_IDLE)) begin
        tok_d[i]   = '0;
        down_d[i]  = 1'b0;
        state_d[i] = ST_RUN;
      end else if (ch_en_i[i] && (state_q[i] == ST_RUN)) begin
        unique case (mode_q[i])
          MODE_WRAP: begin
            if (tok_q[i] < max_q[i]) begin
              tok_d[i] = tok_q[i] + TOKEN_W'(1);
            end else begin
              tok_d[i]  = '0;
              wrap_d[i] = 1'b1;
            end
          end
          MODE_ONESHOT: begin
            if (tok_q[i] < max_q[i]) begin
              tok_d[i] = tok_q[i] + TOKEN_W'(1);
            end else begin
              state_d[i] = ST_DONE;
            end
          end
          MODE_PINGPONG: begin
            if (max_q[i] == '0) begin
              // Degenerate range: token pinned at 0, every step is a return
              tok_d[i]  = '0;
              wrap_d[i] = 1'b1;
            end else if (!down_q[i]) begin
              if (tok_q[i] < max_q[i]) begin
                tok_d[i] = tok_q[i] + TOKEN_W'(1);
              end else if (max_q[i] == TOKEN_W'(1)) begin
                // Turning at max=1 lands straight back on 0
                tok_d[i]  = '0;
                wrap_d[i] = 1'b1;
              end else begin
                tok_d[i]  = tok_q[i] - TOKEN_W'(1);
                down_d[i] = 1'b1;
              end
            end else begin
              if (tok_q[i] <= TOKEN_W'(1)) begin
                tok_d[i]  = '0;
                wrap_d[i] = 1'b1;
                down_d[i] = 1'b0;
              end else begin
                tok_d[i] = tok_q[i] - TOKEN_W'(1);
              end
            end
          end
          default: begin
            tok_d[i] = tok_q[i];
          end
        endcase
      end

      done_d[i] = (state_d[i] == ST_DONE);
    end

    all_done_d = &done_q;
    cfg_err_d  = cfg_valid_i && !cfg_ok;
  end

  // State and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_IDLE;
        mode_q[i]  <= MODE_WRAP;
        max_q[i]   <= '0;
        tok_q[i]   <= '0;
      end
      down_q     <= '0;
      wrap_q     <= '0;
      done_q     <= '0;
      all_done_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        mode_q[i]  <= mode_d[i];
        max_q[i]   <= max_d[i];
        tok_q[i]   <= tok_d[i];
      end
      down_q     <= down_d;
      wrap_q     <= wrap_d;
      done_q     <= done_d;
      all_done_q <= all_done_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  // Pack per-channel token registers onto the flat output bus
  for (genvar g = 0; g < NUM_CH; g++) begin : g_tok
    assign token_o[g*TOKEN_W +: TOKEN_W] = tok_q[g];
  end

  assign wrap_pulse_o = wrap_q;
  assign done_o       = done_q;
  assign all_done_o   = all_done_q;
  assign cfg_err_o    = cfg_err_q;

endmodule

// File: tb/tb_token_sequencer.sv
// Scoreboard bench for token_sequencer (5 channels so an out-of-range channel
// index is representable). Driver queues expected outputs, monitor checks.
module tb_token_sequencer;

  localparam int unsigned NCH = 5;
  localparam int unsigned TW  = 8;
  localparam int unsigned CHW = 3;

  logic              clk;
  logic              rst;
  logic              cfg_valid;
  logic [CHW-1:0]    cfg_ch;
  logic [TW-1:0]     cfg_max;
  logic [1:0]        cfg_mode;
  logic [NCH-1:0]    ch_en;
  logic [NCH-1:0]    ch_clear;
  logic [NCH*TW-1:0] token;
  logic [NCH-1:0]    wrap_pulse;
  logic [NCH-1:0]    done;
  logic              all_done;
  logic              cfg_err;

  token_sequencer #(.NUM_CH(NCH), .TOKEN_W(TW)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cfg_valid_i  (cfg_valid),
    .cfg_ch_i     (cfg_ch),
    .cfg_max_i    (cfg_max),
    .cfg_mode_i   (cfg_mode),
    .ch_en_i      (ch_en),
    .ch_clear_i   (ch_clear),
    .token_o      (token),
    .wrap_pulse_o (wrap_pulse),
    .done_o       (done),
    .all_done_o   (all_done),
    .cfg_err_o    (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int                ch;
    logic [TW-1:0]     tok;
    logic              wrap;
    logic              dn;
    logic              err;
    logic              chk_ad;
    logic              ad;
    logic              chk_vec;
    logic [NCH*TW-1:0] vec;
    string             nm;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  logic              ad_chk  = 1'b0;
  logic              ad_exp  = 1'b0;
  logic              vec_chk = 1'b0;
  logic [NCH*TW-1:0] vec_exp = '0;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endfunction

  // Monitor: every cycle that has a queued expectation is checked after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        check({e.nm, ".tok"},  64'(token[e.ch*TW +: TW]), 64'(e.tok));
        check({e.nm, ".wrap"}, 64'(wrap_pulse[e.ch]),     64'(e.wrap));
        check({e.nm, ".done"}, 64'(done[e.ch]),           64'(e.dn));
        check({e.nm, ".err"},  64'(cfg_err),              64'(e.err));
        if (e.chk_ad)  check({e.nm, ".all_done"}, 64'(all_done), 64'(e.ad));
        if (e.chk_vec) check({e.nm, ".vec"},      64'(token),    64'(e.vec));
      end
    end
  end

  task automatic cyc(input logic [NCH-1:0] en, input logic [NCH-1:0] clr,
                     input logic cv, input int cch, input logic [TW-1:0] cmax,
                     input logic [1:0] cmode, input int ech, input logic [TW-1:0] etok,
                     input logic ewrap, input logic edone, input logic eerr,
                     input string nm);
    exp_t e;
    @(negedge clk);
    ch_en     = en;
    ch_clear  = clr;
    cfg_valid = cv;
    cfg_ch    = CHW'(cch);
    cfg_max   = cmax;
    cfg_mode  = cmode;
    e.ch = ech; e.tok = etok; e.wrap = ewrap; e.dn = edone; e.err = eerr;
    e.chk_ad = ad_chk; e.ad = ad_exp; e.chk_vec = vec_chk; e.vec = vec_exp;
    e.nm = nm;
    ad_chk  = 1'b0;
    vec_chk = 1'b0;
    q.push_back(e);
  endtask

  task automatic en_cyc(input logic [NCH-1:0] en, input int ech, input logic [TW-1:0] etok,
                        input logic ewrap, input logic edone, input string nm);
    cyc(en, '0, 1'b0, 0, '0, 2'd0, ech, etok, ewrap, edone, 1'b0, nm);
  endtask

  task automatic cfg_cyc(input int cch, input logic [TW-1:0] cmax, input logic [1:0] cmode,
                         input string nm);
    cyc('0, '0, 1'b1, cch, cmax, cmode, cch, '0, 1'b0, 1'b0, 1'b0, nm);
  endtask

  task automatic drain();
    @(negedge clk);
    ch_en = '0; ch_clear = '0; cfg_valid = 1'b0;
    for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
    if (q.size() != 0) check("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, ".tok"},      64'(token),      64'd0);
    check({nm, ".wrap"},     64'(wrap_pulse), 64'd0);
    check({nm, ".done"},     64'(done),       64'd0);
    check({nm, ".all_done"}, 64'(all_done),   64'd0);
    check({nm, ".err"},      64'(cfg_err),    64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cfg_valid = 1'b0; cfg_ch = '0; cfg_max = '0; cfg_mode = '0;
    ch_en = '0; ch_clear = '0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // IDLE channels ignore enable
    en_cyc('1, 0, 8'd0, 1'b0, 1'b0, "idle_hold");

    // WRAP ch0 max=3
    cfg_cyc(0, 8'd3, 2'd0, "wrap_cfg");
    en_cyc(5'b00001, 0, 8'd1, 1'b0, 1'b0, "wrap1");
    en_cyc(5'b00001, 0, 8'd2, 1'b0, 1'b0, "wrap2");
    en_cyc(5'b00001, 0, 8'd3, 1'b0, 1'b0, "wrap3");
    en_cyc(5'b00001, 0, 8'd0, 1'b1, 1'b0, "wrap0");
    en_cyc(5'b00001, 0, 8'd1, 1'b0, 1'b0, "wrap1b");

    // ONESHOT ch1 max=2
    cfg_cyc(1, 8'd2, 2'd1, "os_cfg");
    en_cyc(5'b00010, 1, 8'd1, 1'b0, 1'b0, "os1");
    en_cyc(5'b00010, 1, 8'd2, 1'b0, 1'b0, "os2");
    en_cyc(5'b00010, 1, 8'd2, 1'b0, 1'b1, "os_done");
    en_cyc(5'b00010, 1, 8'd2, 1'b0, 1'b1, "os_hold");
    cyc('0, 5'b00010, 1'b0, 0, '0, 2'd0, 1, 8'd0, 1'b0, 1'b0, 1'b0, "os_clear");

    // PINGPONG ch2 max=2
    cfg_cyc(2, 8'd2, 2'd2, "pp_cfg");
    en_cyc(5'b00100, 2, 8'd1, 1'b0, 1'b0, "pp1");
    en_cyc(5'b00100, 2, 8'd2, 1'b0, 1'b0, "pp2");
    en_cyc(5'b00100, 2, 8'd1, 1'b0, 1'b0, "pp1d");
    en_cyc(5'b00100, 2, 8'd0, 1'b1, 1'b0, "pp0");
    en_cyc(5'b00100, 2, 8'd1, 1'b0, 1'b0, "pp1u");
    en_cyc(5'b00100, 2, 8'd2, 1'b0, 1'b0, "pp2u");

    // Simultaneous cfg/clear/enable on ch3, then rejected writes
    cfg_cyc(3, 8'd1, 2'd0, "sim_pre_cfg");
    en_cyc(5'b01000, 3, 8'd1, 1'b0, 1'b0, "sim_pre1");
    cyc(5'b01000, 5'b01000, 1'b1, 3, 8'd5, 2'd1, 3, 8'd0, 1'b0, 1'b0, 1'b0, "sim_write");
    en_cyc(5'b01000, 3, 8'd1, 1'b0, 1'b0, "sim1");
    en_cyc(5'b01000, 3, 8'd2, 1'b0, 1'b0, "sim2");
    vec_chk = 1'b1;
    vec_exp = {8'd0, 8'd2, 8'd2, 8'd0, 8'd1};
    cyc('0, '0, 1'b1, 5, 8'd9, 2'd0, 3, 8'd2, 1'b0, 1'b0, 1'b1, "bad_ch");
    en_cyc('0, 3, 8'd2, 1'b0, 1'b0, "err_once");
    cyc('0, '0, 1'b1, 3, 8'd9, 2'd3, 3, 8'd2, 1'b0, 1'b0, 1'b1, "bad_mode");
    en_cyc(5'b01000, 3, 8'd3, 1'b0, 1'b0, "sim3");
    en_cyc(5'b01000, 3, 8'd4, 1'b0, 1'b0, "sim4");
    en_cyc(5'b01000, 3, 8'd5, 1'b0, 1'b0, "sim5");
    en_cyc(5'b01000, 3, 8'd5, 1'b0, 1'b1, "sim_done");

    // Boundaries on ch4: max=0 in each mode, then max=255
    cfg_cyc(4, 8'd0, 2'd0, "z_wrap_cfg");
    en_cyc(5'b10000, 4, 8'd0, 1'b1, 1'b0, "z_wrap_a");
    en_cyc(5'b10000, 4, 8'd0, 1'b1, 1'b0, "z_wrap_b");
    en_cyc('0,       4, 8'd0, 1'b0, 1'b0, "z_wrap_off");
    cfg_cyc(4, 8'd0, 2'd2, "z_pp_cfg");
    en_cyc(5'b10000, 4, 8'd0, 1'b1, 1'b0, "z_pp");
    cfg_cyc(4, 8'd0, 2'd1, "z_os_cfg");
    en_cyc(5'b10000, 4, 8'd0, 1'b0, 1'b1, "z_os");
    cfg_cyc(4, 8'd255, 2'd0, "full_cfg");
    for (int i = 1; i <= 255; i++) en_cyc(5'b10000, 4, TW'(i), 1'b0, 1'b0, "full_cnt");
    en_cyc(5'b10000, 4, 8'd0, 1'b1, 1'b0, "full_wrap");

    // Mid-count reset with token0 at 2
    en_cyc(5'b00001, 0, 8'd2, 1'b0, 1'b0, "pre_rst");
    drain();
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    vec_chk = 1'b1;
    vec_exp = '0;
    en_cyc('1, 0, 8'd0, 1'b0, 1'b0, "post_rst_idle");

    // all_done: every channel ONESHOT, ch4 finishes last
    cfg_cyc(0, 8'd0, 2'd1, "ad_cfg0");
    cfg_cyc(1, 8'd0, 2'd1, "ad_cfg1");
    cfg_cyc(2, 8'd0, 2'd1, "ad_cfg2");
    cfg_cyc(3, 8'd0, 2'd1, "ad_cfg3");
    cfg_cyc(4, 8'd1, 2'd1, "ad_cfg4");
    ad_chk = 1'b1; ad_exp = 1'b0;
    en_cyc('1, 4, 8'd1, 1'b0, 1'b0, "ad_step1");
    ad_chk = 1'b1; ad_exp = 1'b0;
    en_cyc('1, 4, 8'd1, 1'b0, 1'b1, "ad_last_done");
    ad_chk = 1'b1; ad_exp = 1'b1;
    en_cyc('0, 4, 8'd1, 1'b0, 1'b1, "ad_rise");
    ad_chk = 1'b1; ad_exp = 1'b1;
    cyc('0, 5'b00001, 1'b0, 0, '0, 2'd0, 0, 8'd0, 1'b0, 1'b0, 1'b0, "ad_clear");
    ad_chk = 1'b1; ad_exp = 1'b0;
    en_cyc('0, 0, 8'd0, 1'b0, 1'b0, "ad_fall");

    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
